apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; TIMEOUT, 255, max ACCESS wait cycles (0 = disabled).
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock; all state updates on rising edge.
- rts  in  1  reset; synchronous, active-high.
- m0_paddr/m1_paddr  in  ADDR_WIDTH  master address.
- m0_pdata/m1_pdata  in  DATA_WIDTH  master write data.
- m0_psel/m1_psel, m0_penable/m1_penable, m0_pwrite/m1_pwrite  in  1 each  master APB controls.
- m0_pstb/m1_pstb  in  4  master byte strobes.
- m0_prdata/m1_prdata  out  DATA_WIDTH  read data to master.
- m0_pready/m1_pready, m0_perr/m1_perr  out  1 each  completion/error to master.
- s_paddr  out  ADDR_WIDTH;  s_pdata  out  DATA_WIDTH;  s_psel, s_penable, s_pwrite  out  1;  s_pstb  out  4  shared slave bus.
- s_prdata  in  DATA_WIDTH;  s_pready, s_perr  in  1  slave response.
- busy  out  1  transfer in progress;  owner  out  1  index of current/last granted master.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-004 A master SHALL be requesting when its psel=1; penable not required to request.
REQ-005 In IDLE with exactly one request, SHALL grant that master, move to SETUP next cycle.
REQ-006 In IDLE with both requesting, SHALL grant the master not equal to owner (round-robin).
REQ-007 On grant, SHALL register paddr, pdata, pwrite, pstb of granted master onto s_* and set owner; s_* held constant until return to IDLE.
REQ-008 SETUP: s_psel=1, s_penable=0, exactly one cycle, then ACCESS.
REQ-009 ACCESS: s_psel=1, s_penable=1; remain until s_pready=1 or timeout.
REQ-010 Granted master's pready SHALL equal s_pready in ACCESS (combinational) and perr SHALL equal s_perr & s_pready; both 0 outside ACCESS.
REQ-011 Non-granted master's pready and perr SHALL be 0 always; its request SHALL remain pending untouched.
REQ-012 m0_prdata and m1_prdata SHALL both equal s_prdata combinationally.
REQ-013 On ACCESS with s_pready=1, SHALL return to IDLE next cycle; s_psel, s_penable deassert same edge.
REQ-014 Minimum one IDLE cycle between transfers; earliest pready at third cycle after psel sampled (IDLE, SETUP, ACCESS).
REQ-015 Timeout counter (8+ bits, sized to hold TIMEOUT) SHALL clear on entering ACCESS, increment each ACCESS cycle without s_pready.
REQ-016 When TIMEOUT!=0 and counter reaches TIMEOUT with s_pready=0, SHALL drive granted master pready=1, perr=1 that cycle and return to IDLE.
REQ-017 s_pready=1 in the same cycle as timeout SHALL be a normal completion (perr = s_perr).
REQ-018 If granted master drops psel before completion, SHALL finish slave transfer normally; response discarded by master.
REQ-019 s_pready and s_perr SHALL be ignored in IDLE and SETUP.
REQ-020 busy SHALL be 1 in SETUP and ACCESS, else 0.

Reset
REQ-021 rts=1 SHALL force IDLE, owner=1 (so master 0 wins first tie), counter=0, s_psel=0, s_penable=0, s_paddr=0, s_pdata=0, s_pwrite=0, s_pstb=0, busy=0; all m*_pready/perr=0.
REQ-022 rts asserted mid-transfer SHALL abandon it with no pready to any master; re-arbitration starts the cycle after rts deasserts.

Verification
REQ-023 m0 read 0x100, slave ready first ACCESS cycle, prdata 0xDEADBEEF -> s_psel at cycle 1, s_penable at cycle 2, m0_pready=1, m0_prdata=0xDEADBEEF at cycle 2.
REQ-024 Both request from reset -> m0 served first, then m1; next simultaneous request -> m0 again (alternation).
REQ-025 m1 write 0x20, pdata 0x55, pstb 0x1, slave holds pready=0 for 3 cycles -> s_* stable throughout, m0_pready=0, m1_pready=1 on 4th ACCESS cycle.
REQ-026 TIMEOUT=4, slave never ready -> m0_pready=1, m0_perr=1 on 4th ACCESS cycle counting, FSM IDLE next cycle.
REQ-027 rts pulsed during ACCESS -> s_psel=0 next cycle, no pready issued, owner=1.
REQ-028 Slave pready=1, perr=1 -> granted master perr=1 for exactly one cycle.

Source files
------------

// File: rtl/apb_arbiter.sv
// Two-master to one-slave APB arbiter with round-robin tie-breaking and an ACCESS-phase
// timeout. The granted master's request is registered onto the shared slave bus.
module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rts,

    input  logic [ADDR_WIDTH-1:0] m0_paddr,
    input  logic [DATA_WIDTH-1:0] m0_pdata,
    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic                  m0_pwrite,
    input  logic [3:0]            m0_pstb,
    output logic [DATA_WIDTH-1:0] m0_prdata,
    output logic                  m0_pready,
    output logic                  m0_perr,

    input  logic [ADDR_WIDTH-1:0] m1_paddr,
    input  logic [DATA_WIDTH-1:0] m1_pdata,
    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic                  m1_pwrite,
    input  logic [3:0]            m1_pstb,
    output logic [DATA_WIDTH-1:0] m1_prdata,
    output logic                  m1_pready,
    output logic                  m1_perr,

    output logic [ADDR_WIDTH-1:0] s_paddr,
    output logic [DATA_WIDTH-1:0] s_pdata,
    output logic                  s_psel,
    output logic                  s_penable,
    output logic                  s_pwrite,
    output logic [3:0]            s_pstb,
    input  logic [DATA_WIDTH-1:0] s_prdata,
    input  logic                  s_pready,
    input  logic                  s_perr,

    output logic                  busy,
    output logic                  owner
);

    localparam int CNT_W = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
    localparam bit TMO_EN = (TIMEOUT != 0);
    // The counter holds the number of elapsed not-ready ACCESS cycles, so the
    // timeout fires on the TIMEOUT-th ACCESS cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             grant_idx;
    logic             timeout_hit;
    logic             xfer_done;
    logic             resp_err;

    // Penable is not part of the request; a master asks for the bus with psel alone.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    // On a tie, the master that did not own the bus last time wins.
    assign grant_idx = (m0_psel && m1_psel) ? ~owner : m1_psel;

    assign timeout_hit = TMO_EN && (state == ACCESS) && !s_pready && (tmo_cnt == TMO_LAST);
    assign xfer_done   = (state == ACCESS) && (s_pready || timeout_hit);
    assign resp_err    = (s_pready && s_perr) || timeout_hit;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rts) begin
            state    <= IDLE;
            owner    <= 1'b1;
            tmo_cnt  <= '0;
            s_paddr  <= '0;
            s_pdata  <= '0;
            s_pwrite <= 1'b0;
            s_pstb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (m0_psel || m1_psel) begin
                        state    <= SETUP;
                        owner    <= grant_idx;
                        s_paddr  <= grant_idx ? m1_paddr  : m0_paddr;
                        s_pdata  <= grant_idx ? m1_pdata  : m0_pdata;
                        s_pwrite <= grant_idx ? m1_pwrite : m0_pwrite;
                        s_pstb   <= grant_idx ? m1_pstb   : m0_pstb;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    tmo_cnt <= '0;
                end
                ACCESS: begin
                    if (xfer_done) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_psel    = (state != IDLE);
    assign s_penable = (state == ACCESS);
    assign busy      = (state != IDLE);

    assign m0_prdata = s_prdata;
    assign m1_prdata = s_prdata;

    // A reset arriving during ACCESS must not leak a completion to either master.
    assign m0_pready = !rts && xfer_done && !owner;
    assign m1_pready = !rts && xfer_done &&  owner;
    assign m0_perr   = !rts && xfer_done && !owner && resp_err;
    assign m1_perr   = !rts && xfer_done &&  owner && resp_err;

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: a per-cycle vector table, directed multi-cycle
// sequences, and randomized transactions checked against a transaction-level model.
module tb_apb_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk;
    logic          rts;
    logic [AW-1:0] m0_paddr, m1_paddr;
    logic [DW-1:0] m0_pdata, m1_pdata;
    logic          m0_psel, m1_psel, m0_penable, m1_penable, m0_pwrite, m1_pwrite;
    logic [3:0]    m0_pstb, m1_pstb;
    logic [DW-1:0] m0_prdata, m1_prdata;
    logic          m0_pready, m1_pready, m0_perr, m1_perr;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pdata;
    logic          s_psel, s_penable, s_pwrite;
    logic [3:0]    s_pstb;
    logic [DW-1:0] s_prdata;
    logic          s_pready, s_perr;
    logic          busy, owner;

    int checks   = 0;
    int failures = 0;

    apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rts(rts),
        .m0_paddr(m0_paddr), .m0_pdata(m0_pdata), .m0_psel(m0_psel), .m0_penable(m0_penable),
        .m0_pwrite(m0_pwrite), .m0_pstb(m0_pstb), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
        .m0_perr(m0_perr),
        .m1_paddr(m1_paddr), .m1_pdata(m1_pdata), .m1_psel(m1_psel), .m1_penable(m1_penable),
        .m1_pwrite(m1_pwrite), .m1_pstb(m1_pstb), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
        .m1_perr(m1_perr),
        .s_paddr(s_paddr), .s_pdata(s_pdata), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_pstb(s_pstb), .s_prdata(s_prdata), .s_pready(s_pready),
        .s_perr(s_perr), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rts, p0, p1, rdy, err;
        logic [31:0] rdata;
        logic        e_psel, e_pen, e_r0, e_r1, e_e0, e_e1, e_own;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic rts_v, p0, p1, rdy, err, input logic [31:0] rdata,
                                input logic e_psel, e_pen, e_r0, e_r1, e_e0, e_e1, e_own,
                                input logic [31:0] e_addr);
        vec_t v;
        v.rts = rts_v; v.p0 = p0; v.p1 = p1; v.rdy = rdy; v.err = err; v.rdata = rdata;
        v.e_psel = e_psel; v.e_pen = e_pen; v.e_r0 = e_r0; v.e_r1 = e_r1;
        v.e_e0 = e_e0; v.e_e1 = e_e1; v.e_own = e_own; v.e_addr = e_addr;
        return v;
    endfunction

    vec_t vecs[23];

    // Random-phase request bookkeeping per master.
    bit          pend[2];
    logic [31:0] r_addr[2];
    logic [31:0] r_data[2];
    logic        r_wr[2];
    logic [3:0]  r_stb[2];

    task automatic put_req();
        m0_psel = pend[0]; m0_paddr = r_addr[0]; m0_pdata = r_data[0];
        m0_pwrite = r_wr[0]; m0_pstb = r_stb[0];
        m1_psel = pend[1]; m1_paddr = r_addr[1]; m1_pdata = r_data[1];
        m1_pwrite = r_wr[1]; m1_pstb = r_stb[1];
    endtask

    task automatic step_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, lat, done_k, model_owner;
        logic err_v, exp_err;
        logic exp_r[2];
        logic exp_e[2];

        rts = 1'b1;
        m0_paddr = 32'h100; m0_pdata = 32'h11; m0_pwrite = 1'b0; m0_pstb = 4'hF;
        m1_paddr = 32'h20;  m1_pdata = 32'h55; m1_pwrite = 1'b1; m1_pstb = 4'h1;
        m0_psel = 0; m1_psel = 0; m0_penable = 0; m1_penable = 0;
        s_prdata = '0; s_pready = 0; s_perr = 0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_s_paddr", s_paddr, 0);
        check("rst_s_pdata", s_pdata, 0);
        check("rst_s_pwrite", s_pwrite, 0);
        check("rst_s_pstb", s_pstb, 0);
        check("rst_owner", owner, 1);
        check("rst_busy", busy, 0);

        //           rts p0 p1 rdy err rdata          psel pen r0 r1 e0 e1 own addr
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[2]  = mk(0, 1, 0, 1, 1, 32'h0,          1, 0, 0, 0, 0, 0, 0, 32'h100);
        vecs[3]  = mk(0, 1, 0, 1, 0, 32'hDEADBEEF,   1, 1, 1, 0, 0, 0, 0, 32'h100);
        vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[5]  = mk(1, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[6]  = mk(0, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[7]  = mk(0, 1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0, 32'h100);
        vecs[8]  = mk(0, 1, 1, 1, 1, 32'h1234,       1, 1, 1, 0, 1, 0, 0, 32'h100);
        vecs[9]  = mk(0, 0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[10] = mk(0, 0, 1, 0, 1, 32'h0,          1, 0, 0, 0, 0, 0, 1, 32'h20);
        vecs[11] = mk(0, 0, 1, 1, 0, 32'hCAFE,       1, 1, 0, 1, 0, 0, 1, 32'h20);
        vecs[12] = mk(0, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[13] = mk(0, 1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0, 32'h100);
        vecs[14] = mk(0, 1, 1, 0, 1, 32'h0,          1, 1, 0, 0, 0, 0, 0, 32'h100);
        vecs[15] = mk(1, 1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 32'h100);
        vecs[16] = mk(0, 1, 1, 1, 1, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[17] = mk(0, 1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0, 32'h100);
        vecs[18] = mk(0, 0, 1, 1, 0, 32'h77,         1, 1, 1, 0, 0, 0, 0, 32'h100);
        vecs[19] = mk(0, 0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[20] = mk(0, 0, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 1, 32'h20);
        vecs[21] = mk(0, 0, 1, 1, 0, 32'h9,          1, 1, 0, 1, 0, 0, 1, 32'h20);
        vecs[22] = mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h0);

        for (int i = 0; i < 23; i++) begin
            step_drive();
            rts = vecs[i].rts; m0_psel = vecs[i].p0; m1_psel = vecs[i].p1;
            s_pready = vecs[i].rdy; s_perr = vecs[i].err; s_prdata = vecs[i].rdata;
            #1;
            check($sformatf("vec%0d_s_psel", i), s_psel, vecs[i].e_psel);
            check($sformatf("vec%0d_s_penable", i), s_penable, vecs[i].e_pen);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_psel);
            check($sformatf("vec%0d_m0_pready", i), m0_pready, vecs[i].e_r0);
            check($sformatf("vec%0d_m1_pready", i), m1_pready, vecs[i].e_r1);
            check($sformatf("vec%0d_m0_perr", i), m0_perr, vecs[i].e_e0);
            check($sformatf("vec%0d_m1_perr", i), m1_perr, vecs[i].e_e1);
            check($sformatf("vec%0d_owner", i), owner, vecs[i].e_own);
            check($sformatf("vec%0d_m0_prdata", i), m0_prdata, vecs[i].rdata);
            check($sformatf("vec%0d_m1_prdata", i), m1_prdata, vecs[i].rdata);
            if (vecs[i].e_psel)
                check($sformatf("vec%0d_s_paddr", i), s_paddr, vecs[i].e_addr);
        end

        // m1 write with a slow slave; master inputs wiggle mid-transfer but the bus holds.
        step_drive();
        m1_psel = 1; m1_paddr = 32'h20; m1_pdata = 32'h55; m1_pwrite = 1; m1_pstb = 4'h1;
        s_pready = 0; s_perr = 0;
        step_drive();
        m1_paddr = 32'hFFFF; m1_pdata = 32'hAA; m1_pwrite = 0; m1_pstb = 4'hF;
        #1;
        check("slow_setup_psel", s_psel, 1);
        for (int k = 1; k <= 4; k++) begin
            step_drive();
            s_pready = (k == 4);
            #1;
            check($sformatf("slow_k%0d_paddr", k), s_paddr, 32'h20);
            check($sformatf("slow_k%0d_pdata", k), s_pdata, 32'h55);
            check($sformatf("slow_k%0d_pwrite", k), s_pwrite, 1);
            check($sformatf("slow_k%0d_pstb", k), s_pstb, 4'h1);
            check($sformatf("slow_k%0d_m0_pready", k), m0_pready, 0);
            check($sformatf("slow_k%0d_m1_pready", k), m1_pready, (k == 4));
        end
        step_drive();
        m1_psel = 0; s_pready = 0;
        #1;
        check("slow_done_busy", busy, 0);

        // Slave never ready: timeout completes on the TMO-th ACCESS cycle with an error.
        step_drive();
        m0_psel = 1; m0_paddr = 32'h300;
        step_drive();
        for (int k = 1; k <= TMO; k++) begin
            step_drive();
            s_pready = 0; s_perr = 0;
            #1;
            check($sformatf("tmo_k%0d_m0_pready", k), m0_pready, (k == TMO));
            check($sformatf("tmo_k%0d_m0_perr", k), m0_perr, (k == TMO));
            check($sformatf("tmo_k%0d_m1_pready", k), m1_pready, 0);
        end
        step_drive();
        m0_psel = 0;
        #1;
        check("tmo_after_psel", s_psel, 0);
        check("tmo_after_busy", busy, 0);

        // Ready arriving in the timeout cycle is a normal completion.
        step_drive();
        m0_psel = 1;
        step_drive();
        for (int k = 1; k <= TMO; k++) begin
            step_drive();
            s_pready = (k == TMO); s_perr = 0;
            #1;
            check($sformatf("edge_k%0d_m0_pready", k), m0_pready, (k == TMO));
            check($sformatf("edge_k%0d_m0_perr", k), m0_perr, 0);
        end
        step_drive();
        m0_psel = 0; s_pready = 0;

        // Randomized transactions against a transaction-level model.
        step_drive();
        rts = 1;
        step_drive();
        rts = 0;
        #1;
        check("rnd_rst_owner", owner, 1);
        model_owner = 1;
        pend[0] = 0; pend[1] = 0;
        for (int i = 0; i < 150; i++) begin
            step_drive();
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    pend[m] = ($urandom_range(0, 1) == 1);
                    r_addr[m] = $urandom; r_data[m] = $urandom;
                    r_wr[m] = $urandom_range(0, 1); r_stb[m] = 4'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1;
            put_req();
            s_pready = $urandom_range(0, 1); s_perr = $urandom_range(0, 1);
            w = (pend[0] && pend[1]) ? 1 - model_owner : (pend[1] ? 1 : 0);
            lat = $urandom_range(0, 5);
            err_v = $urandom_range(0, 1);
            done_k = (lat + 1 < TMO) ? lat + 1 : TMO;
            exp_err = (lat + 1 <= TMO) ? err_v : 1'b1;
            #1;
            check("rnd_idle_busy", busy, 0);

            step_drive();
            s_pready = $urandom_range(0, 1); s_perr = $urandom_range(0, 1);
            #1;
            check("rnd_setup_psel", s_psel, 1);
            check("rnd_setup_penable", s_penable, 0);
            check("rnd_setup_owner", owner, w);
            check("rnd_setup_paddr", s_paddr, r_addr[w]);
            check("rnd_setup_pdata", s_pdata, r_data[w]);
            check("rnd_setup_pwrite", s_pwrite, r_wr[w]);
            check("rnd_setup_pstb", s_pstb, r_stb[w]);
            check("rnd_setup_pready", m0_pready | m1_pready, 0);

            for (int k = 1; k <= done_k; k++) begin
                step_drive();
                s_pready = (k > lat);
                s_perr = (k > lat) ? err_v : 1'($urandom_range(0, 1));
                s_prdata = $urandom;
                exp_r[0] = 0; exp_r[1] = 0; exp_e[0] = 0; exp_e[1] = 0;
                exp_r[w] = (k == done_k);
                exp_e[w] = (k == done_k) ? exp_err : 1'b0;
                #1;
                check("rnd_acc_penable", s_penable, 1);
                check("rnd_acc_m0_pready", m0_pready, exp_r[0]);
                check("rnd_acc_m1_pready", m1_pready, exp_r[1]);
                check("rnd_acc_m0_perr", m0_perr, exp_e[0]);
                check("rnd_acc_m1_perr", m1_perr, exp_e[1]);
                check("rnd_acc_m0_prdata", m0_prdata, s_prdata);
                check("rnd_acc_m1_prdata", m1_prdata, s_prdata);
            end
            pend[w] = 0;
            model_owner = w;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
